// File: rtl/bcd_sevenseg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sevenseg_scan_if
// Brief    : Digit load / seven-segment display bus for bcd_sevenseg_scan.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_sevenseg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    lzb_en;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (
        output digits_in,
        output load,
        output lzb_en,
        input  seg_n,
        input  an_n,
        input  frame_done
    );

    modport slave (
        input  digits_in,
        input  load,
        input  lzb_en,
        output seg_n,
        output an_n,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/bcd_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_sevenseg_scan
// Brief    : Snapshots packed BCD digits and scans them onto a common-anode
//            seven-segment bus with per-slot blanking and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_sevenseg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    bcd_sevenseg_scan_if.slave bus
);
    localparam int c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w = $clog2(NUM_DIGITS);

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank   = c_cnt_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [6:0]         c_seg_off = 7'h7F;

    logic [4*NUM_DIGITS-1:0] r_snap;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic [3:0]              w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_zero_from;
    logic                    w_slot_end;
    logic                    w_lz_blank;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
    function automatic logic [6:0] encode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    // w_zero_from[i] is set when digits i..NUM_DIGITS-1 of the snapshot are all zero.
    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_digit[i] = r_snap[4*i +: 4];
            if (i == NUM_DIGITS - 1) begin : g_top
                assign w_zero_from[i] = (w_digit[i] == 4'd0);
            end else begin : g_lower
                assign w_zero_from[i] = (w_digit[i] == 4'd0) && w_zero_from[i+1];
            end
        end
    endgenerate

    assign w_slot_end = (r_cnt == c_cnt_max);
    assign w_lz_blank = bus.lzb_en && (r_idx != '0) && w_zero_from[r_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap <= '0;
        end else if (bus.load) begin
            r_snap <= bus.digits_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_slot_end && (r_idx == c_idx_max);
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Anodes stay off at the start of every slot so the previous digit's
    // segments never ghost onto the next anode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= c_seg_off;
            r_an  <= '1;
        end else if (r_cnt < c_blank) begin
            r_seg <= c_seg_off;
            r_an  <= '1;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_lz_blank ? c_seg_off : encode(w_digit[r_idx]);
        end
    end

    assign bus.seg_n      = r_seg;
    assign bus.an_n       = r_an;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_bcd_sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_sevenseg_scan
// Brief    : Directed, table-driven self-checking bench for bcd_sevenseg_scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_sevenseg_scan;
    localparam int NUM_DIGITS   = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYCLES = 1;

    typedef struct {
        logic [15:0]     digits;
        logic            lzb;
        logic [3:0][6:0] seg;   // expected seg_n per digit, index = digit
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    vec_t vecs [8];

    bcd_sevenseg_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    bcd_sevenseg_scan #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (bus.frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.frame_done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: frame_done timeout, got %b expected 1", name, bus.frame_done);
        end
    endtask

    // From a frame_done cycle, check the next 16 samples {frame_done, an_n, seg_n}.
    task automatic check_frame(input string name, input logic [3:0][6:0] seg);
        logic [11:0] exp;
        int s;
        wait_frame(name);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            s = j - 1;
            if (s % 4 == 0) exp = {1'b0, 4'hF, 7'h7F};
            else            exp = {1'b0, ~(4'b0001 << (s / 4)), seg[s / 4]};
            if (j == 16) exp[11] = 1'b1;
            check($sformatf("%s[%0d]", name, j),
                  {20'd0, bus.frame_done, bus.an_n, bus.seg_n}, {20'd0, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{digits: 16'h1234, lzb: 1'b0, seg: {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{digits: 16'h0070, lzb: 1'b1, seg: {7'h7F, 7'h7F, 7'h78, 7'h40}};
        vecs[2] = '{digits: 16'h0070, lzb: 1'b0, seg: {7'h40, 7'h40, 7'h78, 7'h40}};
        vecs[3] = '{digits: 16'h0000, lzb: 1'b1, seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{digits: 16'hFA09, lzb: 1'b0, seg: {7'h3F, 7'h3F, 7'h40, 7'h10}};
        vecs[5] = '{digits: 16'hFA09, lzb: 1'b1, seg: {7'h3F, 7'h3F, 7'h40, 7'h10}};
        vecs[6] = '{digits: 16'h0900, lzb: 1'b1, seg: {7'h7F, 7'h10, 7'h40, 7'h40}};
        vecs[7] = '{digits: 16'h8888, lzb: 1'b0, seg: {7'h00, 7'h00, 7'h00, 7'h00}};

        reset_n       = 1'b0;
        bus.digits_in = '0;
        bus.load      = 1'b0;
        bus.lzb_en    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an",   {28'd0, bus.an_n},       32'hF);
        check("reset_seg",  {25'd0, bus.seg_n},      32'h7F);
        check("reset_fd",   {31'd0, bus.frame_done}, 32'h0);

        reset_n = 1'b1;
        @(negedge clk);
        check("first_blank", {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hF, 7'h7F});
        @(negedge clk);
        check("first_idx0",  {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hE, 7'h40});

        // Load mid-slot, then hit reset asynchronously partway through a cycle.
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        check("load_lat1", {25'd0, bus.seg_n}, 32'h40);
        @(negedge clk);
        check("load_lat2", {25'd0, bus.seg_n}, 32'h19);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst", {20'd0, bus.frame_done, bus.an_n, bus.seg_n}, {20'd0, 1'b0, 4'hF, 7'h7F});
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rerst_blank", {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hF, 7'h7F});
        @(negedge clk);
        check("rerst_snap_clr", {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hE, 7'h40});

        for (int v = 0; v < 8; v++) begin
            bus.digits_in = vecs[v].digits;
            bus.lzb_en    = vecs[v].lzb;
            bus.load      = 1'b1;
            @(negedge clk);
            bus.load = 1'b0;
            check_frame($sformatf("vec%0d", v), vecs[v].seg);
        end

        // Load timing: 9 -> 8 while digit 0 is lit; later input changes must not leak.
        bus.lzb_en    = 1'b0;
        bus.digits_in = 16'h0009;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        wait_frame("lt_sync");
        @(negedge clk);
        @(negedge clk);
        check("lt_d0_on", {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hE, 7'h10});
        bus.digits_in = 16'h0008;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
        bus.digits_in = 16'h0005;
        check("lt_edge1", {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hE, 7'h10});
        @(negedge clk);
        check("lt_edge2", {21'd0, bus.an_n, bus.seg_n}, {21'd0, 4'hE, 7'h00});
        check_frame("lt_hold", {7'h40, 7'h40, 7'h40, 7'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
